// File: rtl/id_ex_pkg.sv
// Shared types for the ID/EX pipeline register: ALU op classes, the control bundle
// carried down the pipe, and the all-zero bundle used when a bubble is inserted.
package id_ex_pkg;

    typedef enum logic [1:0] {
        ALUOP_LOADSTORE = 2'b00,
        ALUOP_BRANCH    = 2'b01,
        ALUOP_RTYPE     = 2'b10,
        ALUOP_ITYPE     = 2'b11
    } aluop_e;

    typedef struct packed {
        aluop_e alu_op;
        logic   reg_write;
        logic   mem_write;
        logic   mem_read;
        logic   mem2reg;
        logic   branch;
    } ctrl_t;

    localparam ctrl_t ZERO_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard check: a valid load in EX whose destination is read by the valid
// instruction in ID. Purely combinational; x0 is never a hazard.
module load_use_detect
    import id_ex_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    output logic              hazard_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rd_i == id_rs_i);
    assign rt_match = id_uses_rt_i & (ex_rd_i == id_rt_i);
    assign hazard_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) & id_valid_i
                    & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with valid, stall hold, flush/hazard bubbles and a saturating bubble counter;
// one-cycle latency, stall freezes all state. PC_PASS_EN adds a pc_i/pc_o payload path.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int FUNCT_W = 10,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
`ifdef PC_PASS_EN
    input  logic [DATA_W-1:0]  pc_i,
    output logic [DATA_W-1:0]  pc_o,
`endif
    input  logic               valid_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [1:0]         ALUOp_i,
    input  logic               ALUSrc_i,
    input  logic               RegWrite_i,
    input  logic               MemWrite_i,
    input  logic               MemRead_i,
    input  logic               Mem2Reg_i,
    input  logic               Branch_i,
    input  logic [DATA_W-1:0]  RSdata_i,
    input  logic [DATA_W-1:0]  RTdata_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [REG_AW-1:0]  RSaddr_i,
    input  logic [REG_AW-1:0]  RTaddr_i,
    input  logic [REG_AW-1:0]  RDaddr_i,
    input  logic               uses_rt_i,
    output logic               valid_o,
    output logic [1:0]         ALUOp_o,
    output logic               RegWrite_o,
    output logic               MemWrite_o,
    output logic               MemRead_o,
    output logic               Mem2Reg_o,
    output logic               Branch_o,
    output logic [DATA_W-1:0]  RSdata_o,
    output logic [DATA_W-1:0]  op2_o,
    output logic [DATA_W-1:0]  RTdata_o,
    output logic [FUNCT_W-1:0] funct_o,
    output logic [REG_AW-1:0]  RSaddr_o,
    output logic [REG_AW-1:0]  RTaddr_o,
    output logic [REG_AW-1:0]  RDaddr_o,
    output logic               hazard_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    ctrl_t              ctrl_q, ctrl_d, in_ctrl;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  rs_data_q, rs_data_d;
    logic [DATA_W-1:0]  op2_q, op2_d;
    logic [DATA_W-1:0]  rt_data_q, rt_data_d;
    logic [FUNCT_W-1:0] funct_q, funct_d;
    logic [REG_AW-1:0]  rs_addr_q, rs_addr_d;
    logic [REG_AW-1:0]  rt_addr_q, rt_addr_d;
    logic [REG_AW-1:0]  rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
    logic               bubble;
`ifdef PC_PASS_EN
    logic [DATA_W-1:0]  pc_q, pc_d;
`endif

    load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_i       (rd_addr_q),
        .id_valid_i    (valid_i),
        .id_rs_i       (RSaddr_i),
        .id_rt_i       (RTaddr_i),
        .id_uses_rt_i  (uses_rt_i),
        .hazard_o      (hazard_o)
    );

    assign in_ctrl = '{alu_op:    aluop_e'(ALUOp_i),
                       reg_write: RegWrite_i,
                       mem_write: MemWrite_i,
                       mem_read:  MemRead_i,
                       mem2reg:   Mem2Reg_i,
                       branch:    Branch_i};

    assign bubble = flush_i | hazard_o | ~valid_i;

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        rs_data_d    = rs_data_q;
        op2_d        = op2_q;
        rt_data_d    = rt_data_q;
        funct_d      = funct_q;
        rs_addr_d    = rs_addr_q;
        rt_addr_d    = rt_addr_q;
        rd_addr_d    = rd_addr_q;
        bubble_cnt_d = bubble_cnt_q;
`ifdef PC_PASS_EN
        pc_d         = pc_q;
`endif
        if (!stall_i) begin
            // Payload fields load even on a bubble; valid_o=0 makes them don't-care.
            rs_data_d = RSdata_i;
            rt_data_d = RTdata_i;
            op2_d     = ALUSrc_i ? imm_i : RTdata_i;
            funct_d   = funct_i;
            rs_addr_d = RSaddr_i;
            rt_addr_d = RTaddr_i;
            rd_addr_d = RDaddr_i;
            if (bubble) begin
                valid_d = 1'b0;
                ctrl_d  = ZERO_CTRL;
            end else begin
                valid_d = 1'b1;
                ctrl_d  = in_ctrl;
`ifdef PC_PASS_EN
                pc_d    = pc_i;
`endif
            end
            // An idle decode slot (!valid_i) is not counted as an inserted bubble.
            if ((flush_i | hazard_o) && (bubble_cnt_q != '1)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            ctrl_q       <= ZERO_CTRL;
            rs_data_q    <= '0;
            op2_q        <= '0;
            rt_data_q    <= '0;
            funct_q      <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rd_addr_q    <= '0;
            bubble_cnt_q <= '0;
`ifdef PC_PASS_EN
            pc_q         <= '0;
`endif
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            rs_data_q    <= rs_data_d;
            op2_q        <= op2_d;
            rt_data_q    <= rt_data_d;
            funct_q      <= funct_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            rd_addr_q    <= rd_addr_d;
            bubble_cnt_q <= bubble_cnt_d;
`ifdef PC_PASS_EN
            pc_q         <= pc_d;
`endif
        end
    end

    assign valid_o      = valid_q;
    assign ALUOp_o      = ctrl_q.alu_op;
    assign RegWrite_o   = ctrl_q.reg_write;
    assign MemWrite_o   = ctrl_q.mem_write;
    assign MemRead_o    = ctrl_q.mem_read;
    assign Mem2Reg_o    = ctrl_q.mem2reg;
    assign Branch_o     = ctrl_q.branch;
    assign RSdata_o     = rs_data_q;
    assign op2_o        = op2_q;
    assign RTdata_o     = rt_data_q;
    assign funct_o      = funct_q;
    assign RSaddr_o     = rs_addr_q;
    assign RTaddr_o     = rt_addr_q;
    assign RDaddr_o     = rd_addr_q;
    assign bubble_cnt_o = bubble_cnt_q;
`ifdef PC_PASS_EN
    assign pc_o         = pc_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table through a scoreboard queue, then hand-written
// stall, stall-with-hazard, reset-under-stall and counter saturation sequences.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i, valid_i, stall_i, flush_i;
    logic [1:0]  ALUOp_i;
    logic        ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i, Branch_i;
    logic [31:0] RSdata_i, RTdata_i, imm_i;
    logic [9:0]  funct_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
    logic        uses_rt_i;
    logic        valid_o;
    logic [1:0]  ALUOp_o;
    logic        RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, Branch_o;
    logic [31:0] RSdata_o, op2_o, RTdata_o;
    logic [9:0]  funct_o;
    logic [4:0]  RSaddr_o, RTaddr_o, RDaddr_o;
    logic        hazard_o;
    logic [15:0] bubble_cnt_o;
`ifdef PC_PASS_EN
    logic [31:0] pc_i, pc_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
`ifdef PC_PASS_EN
        .pc_i(pc_i), .pc_o(pc_o),
`endif
        .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
        .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .Mem2Reg_i(Mem2Reg_i),
        .Branch_i(Branch_i), .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i),
        .funct_i(funct_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .uses_rt_i(uses_rt_i), .valid_o(valid_o), .ALUOp_o(ALUOp_o),
        .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
        .Mem2Reg_o(Mem2Reg_o), .Branch_o(Branch_o), .RSdata_o(RSdata_o), .op2_o(op2_o),
        .RTdata_o(RTdata_o), .funct_o(funct_o), .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o),
        .RDaddr_o(RDaddr_o), .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o)
    );

    typedef struct {
        logic        vld, flush, alusrc, mr, mw, rw, urt;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rtd, imm;
        logic        e_haz, e_vld;
        logic [31:0] e_op2;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[15];
    vec_t sb[$];

    function automatic vec_t mk(input logic vld, flush, alusrc, mr, mw, rw, urt,
                                input logic [4:0] rs, rt, rd,
                                input logic [31:0] rtd, imm,
                                input logic e_haz, e_vld,
                                input logic [31:0] e_op2, input logic [15:0] e_cnt);
        vec_t v;
        v.vld = vld; v.flush = flush; v.alusrc = alusrc; v.mr = mr; v.mw = mw;
        v.rw = rw; v.urt = urt; v.rs = rs; v.rt = rt; v.rd = rd; v.rtd = rtd;
        v.imm = imm; v.e_haz = e_haz; v.e_vld = e_vld; v.e_op2 = e_op2; v.e_cnt = e_cnt;
        return v;
    endfunction

    function automatic logic [1:0] aluop_of(input vec_t v);
        return (v.mr | v.mw) ? 2'b00 : (v.alusrc ? 2'b11 : 2'b10);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int tag);
        valid_i    = v.vld;  flush_i   = v.flush; ALUSrc_i = v.alusrc;
        MemRead_i  = v.mr;   Mem2Reg_i = v.mr;    MemWrite_i = v.mw;
        RegWrite_i = v.rw;   Branch_i  = 1'b0;    uses_rt_i = v.urt;
        RSaddr_i   = v.rs;   RTaddr_i  = v.rt;    RDaddr_i = v.rd;
        RTdata_i   = v.rtd;  imm_i     = v.imm;
        RSdata_i   = 32'h100 + 32'(tag);
        funct_i    = 10'(tag);
        ALUOp_i    = aluop_of(v);
`ifdef PC_PASS_EN
        pc_i       = 32'h1000 + 32'(tag);
`endif
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Full comparison of an EX-side result against a vector's expectation.
    task automatic chk_out(input string nm, input vec_t e, input int tag);
        chk({nm, " valid"},    32'(valid_o),      32'(e.e_vld));
        chk({nm, " memread"},  32'(MemRead_o),    32'(e.e_vld & e.mr));
        chk({nm, " memwrite"}, 32'(MemWrite_o),   32'(e.e_vld & e.mw));
        chk({nm, " regwrite"}, 32'(RegWrite_o),   32'(e.e_vld & e.rw));
        chk({nm, " cnt"},      32'(bubble_cnt_o), 32'(e.e_cnt));
        if (e.e_vld) begin
            chk({nm, " op2"},    op2_o,           e.e_op2);
            chk({nm, " rtdata"}, RTdata_o,        e.rtd);
            chk({nm, " rsdata"}, RSdata_o,        32'h100 + 32'(tag));
            chk({nm, " rd"},     32'(RDaddr_o),   32'(e.rd));
            chk({nm, " funct"},  32'(funct_o),    32'(tag));
            chk({nm, " aluop"},  32'(ALUOp_o),    32'(aluop_of(e)));
        end
    endtask

    initial begin
        vec_t e;
        vec_t hold;
        //           vld fl src mr mw rw urt rs  rt  rd  rtdata    imm      haz vld op2       cnt
        vt[0]  = mk(1, 0, 1, 0, 0, 1, 0, 1,  2,  3,  32'hAB,  32'h10,  0, 1, 32'h10, 0);
        vt[1]  = mk(1, 0, 1, 1, 0, 1, 0, 1,  0,  5,  32'h0,   32'h4,   0, 1, 32'h4,  0);
        vt[2]  = mk(1, 0, 0, 0, 0, 1, 1, 5,  1,  6,  32'h22,  32'h0,   1, 0, 32'h0,  1);
        vt[3]  = mk(1, 0, 0, 0, 0, 1, 1, 5,  1,  6,  32'h22,  32'h0,   0, 1, 32'h22, 1);
        vt[4]  = mk(1, 0, 1, 1, 0, 1, 0, 2,  0,  0,  32'h0,   32'h8,   0, 1, 32'h8,  1);
        vt[5]  = mk(1, 0, 0, 0, 0, 1, 1, 0,  0,  7,  32'h33,  32'h0,   0, 1, 32'h33, 1);
        vt[6]  = mk(1, 0, 1, 1, 0, 1, 0, 0,  0,  9,  32'h0,   32'hC,   0, 1, 32'hC,  1);
        vt[7]  = mk(1, 0, 1, 0, 1, 0, 1, 2,  9,  0,  32'h99,  32'h40,  1, 0, 32'h0,  2);
        vt[8]  = mk(1, 0, 1, 0, 1, 0, 1, 2,  9,  0,  32'h99,  32'h40,  0, 1, 32'h40, 2);
        vt[9]  = mk(1, 0, 1, 1, 0, 1, 0, 3,  0,  4,  32'h0,   32'h14,  0, 1, 32'h14, 2);
        vt[10] = mk(1, 0, 1, 0, 0, 1, 0, 3,  4,  8,  32'h55,  32'h7,   0, 1, 32'h7,  2);
        vt[11] = mk(1, 0, 1, 1, 0, 1, 0, 0,  0,  4,  32'h0,   32'h18,  0, 1, 32'h18, 2);
        vt[12] = mk(0, 0, 0, 0, 0, 1, 0, 4,  0,  1,  32'h0,   32'h0,   0, 0, 32'h0,  2);
        vt[13] = mk(1, 1, 1, 0, 1, 0, 1, 1,  2,  0,  32'h77,  32'h8,   0, 0, 32'h0,  3);
        vt[14] = mk(1, 0, 0, 0, 0, 1, 1, 1,  2,  11, 32'h44,  32'h0,   0, 1, 32'h44, 3);

        rst_i = 1'b1; stall_i = 1'b0;
        drive(vt[0], 0);
        tick(); tick();
        chk("reset valid",  32'(valid_o), 0);
        chk("reset ctrl",   32'({ALUOp_o, RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, Branch_o}), 0);
        chk("reset op2",    op2_o, 0);
        chk("reset rtdata", RTdata_o, 0);
        chk("reset rd",     32'(RDaddr_o), 0);
        chk("reset cnt",    32'(bubble_cnt_o), 0);
        rst_i = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vt[i], i);
            #2;
            chk($sformatf("v%0d hazard", i), 32'(hazard_o), 32'(vt[i].e_haz));
            sb.push_back(vt[i]);
            tick();
            e = sb.pop_front();
            chk_out($sformatf("v%0d", i), e, i);
        end

        // Stall for 3 cycles with changing inputs: vt[14] must stay in EX.
        hold = vt[14];
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(mk(1, c[0], 1, 1, 1, 0, 1, 5'(c + 20), 3, 5'(c + 12),
                     32'(c), 32'hF0 + 32'(c), 0, 0, 0, 0), 40 + c);
            tick();
            chk_out($sformatf("stall%0d", c), hold, 14);
        end
        stall_i = 1'b0;
        drive(mk(1, 0, 1, 1, 0, 1, 0, 1, 0, 12, 0, 32'h5C, 0, 1, 32'h5C, 3), 50);
        hold = mk(1, 0, 1, 1, 0, 1, 0, 1, 0, 12, 0, 32'h5C, 0, 1, 32'h5C, 3);
        tick();
        chk_out("release", hold, 50);

        // Dependent add arrives while stalled: hazard stays high, EX holds the load.
        stall_i = 1'b1;
        drive(mk(1, 0, 0, 0, 0, 1, 1, 12, 2, 13, 32'h66, 0, 1, 1, 32'h66, 4), 60);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("stallhaz%0d hazard", c), 32'(hazard_o), 1);
            tick();
            chk_out($sformatf("stallhaz%0d", c), hold, 50);
        end
        stall_i = 1'b0;
        #2;
        chk("unstall hazard", 32'(hazard_o), 1);
        tick();
        chk("unstall bubble valid", 32'(valid_o), 0);
        chk("unstall bubble memread", 32'(MemRead_o), 0);
        chk("unstall bubble cnt", 32'(bubble_cnt_o), 4);
        #2;
        chk("after bubble hazard", 32'(hazard_o), 0);
        tick();
        chk_out("dep add", mk(1, 0, 0, 0, 0, 1, 1, 12, 2, 13, 32'h66, 0, 1, 1, 32'h66, 4), 60);

        // Reset while stalled with a valid instruction in EX.
        stall_i = 1'b1; rst_i = 1'b1;
        tick();
        chk("rst-stall valid",  32'(valid_o), 0);
        chk("rst-stall ctrl",   32'({ALUOp_o, RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, Branch_o}), 0);
        chk("rst-stall op2",    op2_o, 0);
        chk("rst-stall rsdata", RSdata_o, 0);
        chk("rst-stall rd",     32'(RDaddr_o), 0);
        chk("rst-stall funct",  32'(funct_o), 0);
        chk("rst-stall cnt",    32'(bubble_cnt_o), 0);
        stall_i = 1'b0; rst_i = 1'b0;

        // Flushed stores until the counter saturates.
        drive(mk(1, 1, 1, 0, 1, 0, 1, 1, 2, 0, 32'h77, 32'h8, 0, 0, 0, 0), 70);
        for (int c = 0; c < 65535; c++) tick();
        chk("flush valid",    32'(valid_o), 0);
        chk("flush memwrite", 32'(MemWrite_o), 0);
        chk("sat cnt",        32'(bubble_cnt_o), 32'hFFFF);
        tick(); tick();
        chk("sat hold cnt",   32'(bubble_cnt_o), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
